// File: rtl/upl_tx.sv
// upl_tx: serializes 15-bit uplink words as MSB-first dual-rail pulses on UPL0/UPL1
// with a fixed inter-word gap; key mode expands a 5-bit key into {k, ~k, k}.
module upl_tx #(
  parameter int BIT_PERIOD  = 16,
  parameter int PULSE_WIDTH = 4,
  parameter int GAP_SLOTS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        key_mode,
  input  logic [14:0] word_data,
  input  logic        BLKUPL_,
  output logic        UPL0,
  output logic        UPL1,
  output logic        busy,
  output logic        word_done
);
  localparam int SW = $clog2(BIT_PERIOD);
  localparam int GW = $clog2(GAP_SLOTS + 2);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t        r_state;
  logic [14:0]   r_sr;
  logic [3:0]    r_bit;
  logic [SW-1:0] r_slot;
  logic [GW-1:0] r_gap;
  logic          r_upl0, r_upl1, r_done;
  logic          w_accept, w_last, w_pulse;
  logic [14:0]   w_load;
  always_comb begin
    word_ready = (r_state == IDLE) & BLKUPL_ & ~rst;
    w_accept   = word_valid & word_ready;
    w_last     = r_slot == SW'(BIT_PERIOD - 1);
    w_pulse    = (r_state == SEND) && (int'(r_slot) < PULSE_WIDTH);
    w_load     = key_mode ? {word_data[4:0], ~word_data[4:0], word_data[4:0]} : word_data;
  end
  assign busy      = r_state != IDLE;
  assign UPL0      = r_upl0;
  assign UPL1      = r_upl1;
  assign word_done = r_done;
  // Line registers look at the pre-edge state, so the first pulse lands one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_slot  <= '0;
      r_gap   <= '0;
      r_upl0  <= 1'b0;
      r_upl1  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_upl1 <= w_pulse & r_sr[14];
      r_upl0 <= w_pulse & ~r_sr[14];
      case (r_state)
        IDLE: if (w_accept) begin
          r_sr    <= w_load;
          r_bit   <= 4'd14;
          r_slot  <= '0;
          r_state <= SEND;
        end
        SEND: begin
          r_slot <= w_last ? '0 : r_slot + 1'b1;
          if (w_last) begin
            r_sr  <= r_sr << 1;
            r_bit <= r_bit - 4'd1;
            if (r_bit == 4'd0) begin
              r_gap   <= '0;
              r_done  <= GAP_SLOTS == 0;
              r_state <= GAP_SLOTS == 0 ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          r_slot <= w_last ? '0 : r_slot + 1'b1;
          if (w_last) begin
            r_gap <= r_gap + 1'b1;
            if (r_gap == GW'(GAP_SLOTS - 1)) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
